// File: rtl/rca_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rca_share_ctrl
// Round-robin sharing of one fixed-latency pipelined adder among NUM_REQ
// requesters, with tagged result return and an enable/drain controller.
// Rev    : 1.0  initial release
// ============================================================================
module rca_share_ctrl #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic [WIDTH-1:0]         add_a_o,
  output logic [WIDTH-1:0]         add_b_o,
  input  logic [WIDTH:0]           add_sum_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [WIDTH:0]           rsp_sum_o,
  output logic                     busy_o,
  output logic                     drain_done_o,
  output logic [15:0]              ops_cnt_o
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic [15:0]      ops_cnt_q;
  logic             drain_done_q;

  // Tag pipe: entry 0 is the issue slot, entry LATENCY lines up with add_sum.
  logic [LATENCY:0] tag_vld_q;
  logic [IDW-1:0]   tag_id_q [LATENCY+1];

  logic             fire_d;
  logic [IDW-1:0]   gnt_id_d;
  logic [IDW-1:0]   scan_id;
  logic             busy_w;

  // Scan offsets high to low so the lowest offset from ptr wins.
  always_comb begin : grant_arb
    fire_d      = 1'b0;
    gnt_id_d    = '0;
    scan_id     = '0;
    req_ready_o = '0;
    if (state_q == ST_RUN) begin
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        scan_id = IDW'((int'(ptr_q) + off) % NUM_REQ);
        if (req_valid_i[scan_id]) begin
          fire_d   = 1'b1;
          gnt_id_d = scan_id;
        end
      end
      if (fire_d) begin
        req_ready_o[gnt_id_d] = 1'b1;
      end
    end
  end

  always_comb begin : ptr_next
    ptr_d = (gnt_id_d == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_d + 1'b1;
  end

  assign busy_w = |tag_vld_q;

  always_ff @(posedge clk or posedge rst) begin : ctrl_fsm
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      ops_cnt_q    <= '0;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!en_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (en_i) begin
            state_q <= ST_RUN;
          end else if (!busy_w) begin
            state_q      <= ST_IDLE;
            drain_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (fire_d) begin
        add_a_q   <= req_a_i[int'(gnt_id_d)*WIDTH +: WIDTH];
        add_b_q   <= req_b_i[int'(gnt_id_d)*WIDTH +: WIDTH];
        ptr_q     <= ptr_d;
        ops_cnt_q <= ops_cnt_q + 16'd1;
      end
    end
  end

  // Bubbles shift in on idle cycles so the tag stays aligned with the adder.
  always_ff @(posedge clk or posedge rst) begin : tag_pipe
    if (rst) begin
      tag_vld_q <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_vld_q[0] <= fire_d;
      tag_id_q[0]  <= gnt_id_d;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  always_comb begin : rsp_decode
    rsp_valid_o = '0;
    if (tag_vld_q[LATENCY]) begin
      rsp_valid_o[tag_id_q[LATENCY]] = 1'b1;
    end
  end

  assign rsp_sum_o    = add_sum_i;
  assign add_a_o      = add_a_q;
  assign add_b_o      = add_b_q;
  assign busy_o       = busy_w;
  assign drain_done_o = drain_done_q;
  assign ops_cnt_o    = ops_cnt_q;

endmodule
`default_nettype wire
